// File: rtl/packet_grant_mux_if.sv
// Bundle of the per-port input channels, the arbiter request/grant pair and
// the merged output channel of packet_grant_mux.
interface packet_grant_mux_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
);
  logic [NUM_PORTS-1:0]        valid_i;
  logic [NUM_PORTS*DATA_W-1:0] data_i;
  logic [NUM_PORTS-1:0]        last_i;
  logic [NUM_PORTS-1:0]        ready_o;
  logic [NUM_PORTS-1:0]        requests_o;
  logic [NUM_PORTS-1:0]        grants_i;
  logic                        valid_o;
  logic [DATA_W-1:0]           data_o;
  logic                        last_o;
  logic                        ready_i;
  logic [NUM_PORTS-1:0]        owner_o;
  logic                        busy_o;
  logic                        err_o;

  // Design-side view.
  modport slave (
    input  valid_i, data_i, last_i, grants_i, ready_i,
    output ready_o, requests_o, valid_o, data_o, last_o, owner_o, busy_o, err_o
  );

  // Environment-side view (sources, arbiter, sink).
  modport master (
    output valid_i, data_i, last_i, grants_i, ready_i,
    input  ready_o, requests_o, valid_o, data_o, last_o, owner_o, busy_o, err_o
  );
endinterface

// File: rtl/packet_grant_mux.sv
// Packet-level output stage behind a fixed-priority arbiter: locks the granted
// port for a whole packet, muxes its beats onto one valid/ready channel and
// releases on last, or forcibly (with an error pulse) at MAX_BEATS beats.
module packet_grant_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  packet_grant_mux_if.slave  bus
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]        MAX_CNT = CW'(MAX_BEATS);
  localparam logic [NUM_PORTS-1:0] NP_ONE  = NUM_PORTS'(1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic                 locked;
  logic [NUM_PORTS-1:0] grant_low;
  logic [CW-1:0]        cnt_inc;
  logic                 beat;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_valid;
  logic                 sel_last;

  assign locked    = (state_q == LOCKED);
  // An illegal multi-hot grant collapses to its lowest set bit.
  assign grant_low = bus.grants_i & ((~bus.grants_i) + NP_ONE);
  assign cnt_inc   = cnt_q + CW'(1);

  // One-hot AND-OR select of the owner's channel; all zero when owner_q is 0.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (owner_q[p]) begin
        sel_data  = sel_data | bus.data_i[p*DATA_W +: DATA_W];
        sel_valid = sel_valid | bus.valid_i[p];
        sel_last  = sel_last | bus.last_i[p];
      end
    end
  end

  // The arbiter is masked while a packet holds the lock.
  assign bus.requests_o = locked ? '0 : bus.valid_i;
  assign bus.valid_o    = locked & sel_valid;
  assign bus.data_o     = bus.valid_o ? sel_data : '0;
  assign bus.last_o     = locked & sel_last;
  assign bus.ready_o    = locked ? (owner_q & {NUM_PORTS{bus.ready_i}}) : '0;
  assign bus.owner_o    = owner_q;
  assign bus.busy_o     = locked;
  assign bus.err_o      = err_q;

  assign beat = bus.valid_o & bus.ready_i;

  // Lock on grant, count beats, release on last or on reaching MAX_BEATS.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.grants_i) begin
          state_d = LOCKED;
          owner_d = grant_low;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (beat) begin
          if (bus.last_o) begin
            state_d = IDLE;
            owner_d = '0;
            cnt_d   = '0;
          end else if (cnt_inc == MAX_CNT) begin
            state_d = IDLE;
            owner_d = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, owner, beat counter and error pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_packet_grant_mux.sv
// Directed bench for packet_grant_mux with a packet-level reference model and
// a per-cycle output comparison.
module tb_packet_grant_mux;

  localparam int NP   = 4;
  localparam int DW   = 32;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packet_grant_mux_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

  packet_grant_mux #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_BEATS(MAXB)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] din [NP];
  logic          ovr_en = 1'b0;
  logic [NP-1:0] ovr    = '0;

  assign bus.data_i = {din[3], din[2], din[1], din[0]};

  function automatic logic [NP-1:0] lowest_bit(input logic [NP-1:0] v);
    logic [NP-1:0] r;
    r = '0;
    for (int i = NP - 1; i >= 0; i--) if (v[i]) r = '0 | (NP'(1) << i);
    return r;
  endfunction

  function automatic logic [1:0] lowest_idx(input logic [NP-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NP - 1; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Fixed-priority arbiter (lowest index wins), with an override to inject
  // illegal multi-hot grants.
  always_comb begin
    if (ovr_en) bus.grants_i = ovr;
    else        bus.grants_i = lowest_bit(bus.requests_o);
  end

  // ---------------- reference model ----------------
  bit         m_locked = 1'b0;
  logic [1:0] m_idx    = 2'd0;
  int         m_beats  = 0;
  bit         m_err    = 1'b0;

  logic [NP-1:0] m_gnt;
  logic [NP-1:0] e_req, e_ready, e_owner;
  logic          e_valid, e_last, e_busy;
  logic [DW-1:0] e_data;

  always_comb begin
    m_gnt = ovr_en ? ovr : lowest_bit(bus.valid_i);
  end

  always_comb begin
    e_req   = '0;
    e_ready = '0;
    e_owner = '0;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_busy  = 1'b0;
    e_data  = '0;
    if (!m_locked) begin
      e_req = bus.valid_i;
    end else begin
      e_busy         = 1'b1;
      e_owner[m_idx] = 1'b1;
      e_valid        = bus.valid_i[m_idx];
      e_last         = bus.last_i[m_idx];
      if (e_valid) e_data = din[m_idx];
      if (bus.ready_i) e_ready[m_idx] = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_locked <= 1'b0;
      m_idx    <= 2'd0;
      m_beats  <= 0;
      m_err    <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (!m_locked) begin
        if (m_gnt != '0) begin
          m_locked <= 1'b1;
          m_idx    <= lowest_idx(m_gnt);
          m_beats  <= 0;
        end
      end else if (e_valid && bus.ready_i) begin
        m_beats <= m_beats + 1;
        if (e_last) begin
          m_locked <= 1'b0;
        end else if (m_beats + 1 == MAXB) begin
          m_locked <= 1'b0;
          m_err    <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("requests_o", 64'(bus.requests_o), 64'(e_req));
    check("ready_o",    64'(bus.ready_o),    64'(e_ready));
    check("valid_o",    64'(bus.valid_o),    64'(e_valid));
    check("data_o",     64'(bus.data_o),     64'(e_data));
    check("last_o",     64'(bus.last_o),     64'(e_last));
    check("owner_o",    64'(bus.owner_o),    64'(e_owner));
    check("busy_o",     64'(bus.busy_o),     64'(e_busy));
    check("err_o",      64'(bus.err_o),      64'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] got [4];
  int            k;

  initial begin
    bus.valid_i = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b0;
    for (int i = 0; i < NP; i++) din[i] = '0;

    // Reset values
    bus.valid_i = 4'b0101;
    tick();
    #1;
    check("rst owner", 64'(bus.owner_o), 64'h0);
    check("rst busy",  64'(bus.busy_o),  64'h0);
    check("rst err",   64'(bus.err_o),   64'h0);
    check("rst valid", 64'(bus.valid_o), 64'h0);
    check("rst data",  64'(bus.data_o),  64'h0);
    check("rst req",   64'(bus.requests_o), 64'h5);
    bus.valid_i = '0;
    tick();
    rst_n = 1'b1;
    bus.ready_i = 1'b1;
    tick();

    // Priority and lock: port 1 beats port 3, then port 3 after one dead cycle
    bus.valid_i = 4'b1010;
    din[1] = 32'hA1;
    din[3] = 32'h33;
    #1;
    check("prio req", 64'(bus.requests_o), 64'hA);
    tick();
    #1;
    check("prio owner", 64'(bus.owner_o), 64'h2);
    check("prio req locked", 64'(bus.requests_o), 64'h0);
    check("prio beat1", 64'(bus.data_o), 64'hA1);
    tick();
    din[1] = 32'hA2;
    #1;
    check("prio beat2", 64'(bus.data_o), 64'hA2);
    tick();
    din[1] = 32'hA3;
    bus.last_i = 4'b0010;
    #1;
    check("prio beat3", 64'(bus.data_o), 64'hA3);
    check("prio last", 64'(bus.last_o), 64'h1);
    tick();
    bus.valid_i = 4'b1000;
    bus.last_i  = 4'b1000;
    #1;
    check("dead busy", 64'(bus.busy_o), 64'h0);
    check("dead req", 64'(bus.requests_o), 64'h8);
    tick();
    #1;
    check("port3 owner", 64'(bus.owner_o), 64'h8);
    check("port3 data", 64'(bus.data_o), 64'h33);
    tick();
    bus.valid_i = '0;
    bus.last_i  = '0;
    tick();

    // Backpressure: port 0, 4 beats, ready toggling
    bus.valid_i = 4'b0001;
    bus.ready_i = 1'b0;
    tick();
    k = 0;
    for (int i = 0; i < 7; i++) begin
      bus.ready_i = (i % 2 == 0);
      din[0]      = 32'hB0 + 32'(k);
      bus.last_i  = (k == 3) ? 4'b0001 : 4'b0000;
      #1;
      check("bp ready_o", 64'(bus.ready_o), 64'({3'b000, bus.ready_i}));
      if (bus.valid_o && bus.ready_i && k < 4) begin
        got[k] = bus.data_o;
        k++;
      end
      tick();
    end
    bus.valid_i = '0;
    bus.last_i  = '0;
    bus.ready_i = 1'b1;
    #1;
    check("bp beats", 64'(k), 64'd4);
    for (int i = 0; i < 4; i++) check("bp data", 64'(got[i]), 64'(32'hB0 + 32'(i)));
    check("bp released", 64'(bus.busy_o), 64'h0);
    tick();

    // Owner stall: port 1 drops valid for 5 cycles while port 0 is valid
    bus.valid_i = 4'b0010;
    din[1] = 32'hC1;
    tick();
    tick();
    bus.valid_i = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall busy",  64'(bus.busy_o),  64'h1);
      check("stall owner", 64'(bus.owner_o), 64'h2);
      check("stall valid", 64'(bus.valid_o), 64'h0);
      tick();
    end
    bus.valid_i = 4'b0010;
    bus.last_i  = 4'b0010;
    din[1] = 32'hC2;
    #1;
    check("stall resume", 64'(bus.data_o), 64'hC2);
    tick();
    bus.valid_i = '0;
    bus.last_i  = '0;
    tick();

    // Max-length overflow on port 3
    bus.valid_i = 4'b1000;
    tick();
    for (int i = 0; i < MAXB; i++) begin
      din[3] = 32'h100 + 32'(i);
      tick();
    end
    #1;
    check("ovf err",   64'(bus.err_o),   64'h1);
    check("ovf busy",  64'(bus.busy_o),  64'h0);
    check("ovf owner", 64'(bus.owner_o), 64'h0);
    tick();
    #1;
    check("ovf err once", 64'(bus.err_o),   64'h0);
    check("ovf regrant",  64'(bus.owner_o), 64'h8);
    bus.last_i = 4'b1000;
    tick();
    bus.valid_i = '0;
    bus.last_i  = '0;
    tick();

    // Multi-hot grant sanitised; single-beat packet
    ovr_en = 1'b1;
    ovr    = 4'b0110;
    bus.valid_i = 4'b0110;
    tick();
    ovr_en = 1'b0;
    bus.valid_i = 4'b0010;
    bus.last_i  = 4'b0010;
    din[1] = 32'hD1;
    #1;
    check("mh owner", 64'(bus.owner_o), 64'h2);
    check("mh data",  64'(bus.data_o),  64'hD1);
    check("mh last",  64'(bus.last_o),  64'h1);
    tick();
    bus.valid_i = '0;
    bus.last_i  = '0;
    #1;
    check("single idle", 64'(bus.busy_o), 64'h0);
    tick();

    // Reset mid-packet on port 2
    bus.valid_i = 4'b0100;
    tick();
    for (int i = 0; i < 3; i++) begin
      din[2] = 32'hE0 + 32'(i);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mrst owner", 64'(bus.owner_o), 64'h0);
    check("mrst busy",  64'(bus.busy_o),  64'h0);
    check("mrst err",   64'(bus.err_o),   64'h0);
    check("mrst ready", 64'(bus.ready_o), 64'h0);
    tick();
    rst_n = 1'b1;
    bus.valid_i = 4'b0101;
    #1;
    check("mrst req", 64'(bus.requests_o), 64'h5);
    tick();
    bus.valid_i = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
